ram_rw_ctrl: RTL

RAM_RW_CTRL -- requirements
Module: ram_rw_ctrl

---
 rtl/ram_rw_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/ram_rw_ctrl.sv
// ram_rw_ctrl: writes an address-derived pattern to a RAM, reads it back and counts mismatching words.
//   sys_clk, sys_rst       : clock and synchronous active-high reset
//   start                  : one-cycle request for a write-then-verify pass (honoured only in IDLE)
//   ram_en, ram_we         : RAM port enable / write enable
//   ram_addr, ram_wr_data  : RAM address and write data
//   ram_rd_data            : RAM read data, valid RD_LAT cycles after its read address
//   busy, done             : pass in progress / one-cycle end-of-pass pulse
//   err, err_cnt           : sticky mismatch flag and mismatch count of the current or last pass
module ram_rw_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1,
    parameter logic [DATA_W-1:0] SEED = '0
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              start,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   err_cnt
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   CNT_MAX    = (ADDR_W + 1)'(DEPTH);
    localparam logic [1:0]        DRAIN_LAST = 2'(RD_LAT - 1);

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic [1:0]        r_drain;
    logic              r_en;
    logic              r_we;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [ADDR_W:0]   r_err_cnt;
    logic [RD_LAT-1:0] r_dv;
    logic [DATA_W-1:0] r_exp [RD_LAT];

    logic              w_last;
    logic [ADDR_W-1:0] w_addr_nx;
    logic [DATA_W-1:0] w_pat;
    logic [DATA_W-1:0] w_pat_nx;
    logic              w_miss;

    assign w_last    = r_addr == ADDR_LAST;
    assign w_addr_nx = r_addr + ADDR_W'(1);
    assign w_pat     = DATA_W'(r_addr) + SEED;
    assign w_pat_nx  = DATA_W'(w_addr_nx) + SEED;
    // the oldest delay-line slot lines up with the data the RAM returns this cycle
    assign w_miss    = r_dv[RD_LAT-1] && (ram_rd_data != r_exp[RD_LAT-1]);

    // valid bits of the expected-data delay line; only these need clearing on reset
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_dv <= '0;
        end else begin
            r_dv[0] <= r_state == S_READ;
            for (int i = 1; i < RD_LAT; i++) r_dv[i] <= r_dv[i-1];
        end
    end

    always_ff @(posedge sys_clk) begin
        r_exp[0] <= w_pat;
        for (int i = 1; i < RD_LAT; i++) r_exp[i] <= r_exp[i-1];
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_wr_data <= '0;
            r_drain   <= '0;
            r_en      <= 1'b0;
            r_we      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_miss) begin
                r_err <= 1'b1;
                if (r_err_cnt != CNT_MAX) r_err_cnt <= r_err_cnt + (ADDR_W + 1)'(1);
            end
            case (r_state)
                S_IDLE: if (start) begin
                    r_state   <= S_WRITE;
                    r_en      <= 1'b1;
                    r_we      <= 1'b1;
                    r_addr    <= '0;
                    r_wr_data <= SEED;
                    r_busy    <= 1'b1;
                    r_err     <= 1'b0;
                    r_err_cnt <= '0;
                end
                S_WRITE: if (w_last) begin
                    r_state <= S_READ;
                    r_we    <= 1'b0;
                    r_addr  <= '0;
                end else begin
                    r_addr    <= w_addr_nx;
                    r_wr_data <= w_pat_nx;
                end
                S_READ: if (w_last) begin
                    r_state <= S_DRAIN;
                    r_en    <= 1'b0;
                    r_addr  <= '0;
                    r_drain <= '0;
                end else begin
                    r_addr <= w_addr_nx;
                end
                // the last RD_LAT reads are still in flight; wait for their compares
                S_DRAIN: if (r_drain == DRAIN_LAST) begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end else begin
                    r_drain <= r_drain + 2'd1;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ram_en      = r_en;
    assign ram_we      = r_we;
    assign ram_addr    = r_addr;
    assign ram_wr_data = r_wr_data;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;
    assign err_cnt     = r_err_cnt;
endmodule
